// File: rtl/seq_restoring_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master side issues start/a/b, and the slave side returns busy/done/q/r/div_zero.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_zero
  );

endinterface : seq_restoring_divider_if

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider. One ripple subtraction runs per quotient bit, MSB first.
// All outputs are registered. A zero divisor takes a one-cycle settle in DONE before done pulses.
module seq_restoring_divider #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_restoring_divider_if.slave dif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shift register
  logic [WIDTH-1:0] dvs_q, dvs_d;   // captured divisor
  logic [WIDTH-1:0] pr_q, pr_d;     // partial remainder; restored value is always < divisor
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   pr_shift;
  logic [WIDTH:0]   sub_y;
  logic [WIDTH:0]   borrow;
  logic [WIDTH:0]   diff;
  logic             neg;
  logic [WIDTH-1:0] pr_next;
  logic [WIDTH-1:0] quo_next;
  logic             accept;

  // Ripple subtractor: pr' - {0, divisor}, evaluated WIDTH+1 bits wide.
  always_comb begin
    pr_shift = {pr_q, dvd_q[WIDTH-1]};
    sub_y    = {1'b0, dvs_q};
    borrow   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      borrow[i+1] = (~pr_shift[i] & sub_y[i]) | (~(pr_shift[i] ^ sub_y[i]) & borrow[i]);
    end
    diff     = pr_shift ^ sub_y ^ borrow;
    neg      = diff[WIDTH];
    pr_next  = neg ? pr_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~neg};
  end

  // A new request is taken in IDLE, or on the done cycle for back-to-back operation.
  assign accept = dif.start && ((state_q == S_IDLE) || ((state_q == S_DONE) && done_q));

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        pr_d  = pr_next;
        quo_d = quo_next;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          q_d     = quo_next;
          r_d     = pr_next;
          dz_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!done_q) begin
          // Zero-divisor settle cycle. The untouched dividend register still holds a.
          q_d    = '1;
          r_d    = dvd_q;
          dz_d   = 1'b1;
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      dvd_d = dif.a;
      dvs_d = dif.b;
      pr_d  = '0;
      quo_d = '0;
      cnt_d = '0;
      if (dif.b != '0) begin
        state_d = S_RUN;
        busy_d  = 1'b1;
      end else begin
        state_d = S_DONE;
        busy_d  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign dif.busy     = busy_q;
  assign dif.done     = done_q;
  assign dif.q        = q_q;
  assign dif.r        = r_q;
  assign dif.div_zero = dz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider.
// Results are compared against plain integer division; a zero divisor returns all ones and the dividend.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seq_restoring_divider_if #(.WIDTH(W)) dif ();

  seq_restoring_divider #(.WIDTH(W), .CNT_W(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {q, r, div_zero}.
  function automatic logic [2*W:0] model(input int a, input int b);
    if (b == 0) return {{W{1'b1}}, W'(a), 1'b1};
    return {W'(a / b), W'(a % b), 1'b0};
  endfunction

  // Issues one request. lat counts edges after the accepting edge until done is seen.
  task automatic do_op(input int a, input int b, output logic [2*W:0] res,
                       output int lat, output logic busy_seen);
    dif.a     = W'(a);
    dif.b     = W'(b);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    lat       = 0;
    busy_seen = 1'b0;
    while (!dif.done && lat < 20) begin
      busy_seen |= dif.busy;
      tick();
      lat++;
    end
    res = {dif.q, dif.r, dif.div_zero};
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    repeat (2) tick();
    checks++;
    if ({dif.busy, dif.done, dif.q, dif.r, dif.div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dz=%b, want all zero",
               dif.busy, dif.done, dif.q, dif.r, dif.div_zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int a_tab [5] = '{15, 13, 2, 15, 7};
    int b_tab [5] = '{3, 4, 9, 1, 0};
    logic [2*W:0] res, exp;
    int lat, exp_lat;
    logic bs;
    for (int i = 0; i < 5; i++) begin
      do_op(a_tab[i], b_tab[i], res, lat, bs);
      exp     = model(a_tab[i], b_tab[i]);
      exp_lat = (b_tab[i] == 0) ? 1 : W;
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL directed_result %0d/%0d: got %h, want %h", a_tab[i], b_tab[i], res, exp);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL directed_latency %0d/%0d: got %0d, want %0d", a_tab[i], b_tab[i], lat, exp_lat);
      end
      checks++;
      if ({bs, dif.busy} !== {b_tab[i] != 0, 1'b0}) begin
        errors++;
        $display("FAIL directed_busy %0d/%0d: got seen=%b at_done=%b, want seen=%b at_done=0",
                 a_tab[i], b_tab[i], bs, dif.busy, b_tab[i] != 0);
      end
      tick();
      checks++;
      if ({dif.done, dif.q, dif.r, dif.div_zero} !== {1'b0, exp}) begin
        errors++;
        $display("FAIL directed_after_done %0d/%0d: got done=%b res=%h, want done=0 res=%h",
                 a_tab[i], b_tab[i], dif.done, {dif.q, dif.r, dif.div_zero}, exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [2*W:0] res, exp;
    int a, b, lat;
    logic bs;
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      do_op(a, b, res, lat, bs);
      exp = model(a, b);
      checks++;
      if (res !== exp || lat !== ((b == 0) ? 1 : W)) begin
        errors++;
        $display("FAIL random %0d/%0d: got res=%h lat=%0d, want res=%h lat=%0d",
                 a, b, res, lat, exp, (b == 0) ? 1 : W);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int early = 0;
    int lat;
    dif.a     = 4'd13;
    dif.b     = 4'd4;
    dif.start = 1'b1;
    tick();
    for (int i = 1; i < W; i++) begin
      dif.a = W'($urandom);
      dif.b = W'($urandom);
      tick();
      if (dif.done) early++;
    end
    dif.a = W'($urandom);
    dif.b = W'($urandom);
    tick();
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL b2b_early_done: got %0d pulses, want 0", early);
    end
    checks++;
    if ({dif.done, dif.q, dif.r, dif.div_zero} !== {1'b1, model(13, 4)}) begin
      errors++;
      $display("FAIL b2b_first: got done=%b q=%0d r=%0d dz=%b, want done=1 q=3 r=1 dz=0",
               dif.done, dif.q, dif.r, dif.div_zero);
    end
    dif.a = 4'd9;
    dif.b = 4'd2;
    tick();
    dif.start = 1'b0;
    checks++;
    if ({dif.done, dif.busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", dif.done, dif.busy);
    end
    lat = 0;
    while (!dif.done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if ({dif.q, dif.r, dif.div_zero} !== model(9, 2) || lat !== W) begin
      errors++;
      $display("FAIL b2b_second: got q=%0d r=%0d dz=%b lat=%0d, want q=4 r=1 dz=0 lat=%0d",
               dif.q, dif.r, dif.div_zero, lat, W);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    logic [2*W:0] res;
    int lat;
    logic bs;
    dif.a     = 4'd15;
    dif.b     = 4'd3;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({dif.busy, dif.done, dif.q, dif.r, dif.div_zero} !== '0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b q=%0d r=%0d dz=%b, want all zero",
               dif.busy, dif.done, dif.q, dif.r, dif.div_zero);
    end
    repeat (8) begin
      tick();
      if (dif.done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses, want 0", pulses);
    end
    do_op(15, 3, res, lat, bs);
    checks++;
    if (res !== model(15, 3) || lat !== W) begin
      errors++;
      $display("FAIL abort_rerun: got res=%h lat=%0d, want res=%h lat=%0d", res, lat, model(15, 3), W);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [2*W:0] res;
    int lat;
    logic bs;
    int qv, rv;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a, b, res, lat, bs);
        qv = int'(res[2*W:W+1]);
        rv = int'(res[W:1]);
        checks++;
        if (lat >= 20) begin
          errors++;
          $display("FAIL sweep_timeout %0d/%0d: got no done, want done", a, b);
        end else if (res[0] !== (b == 0)) begin
          errors++;
          $display("FAIL sweep_dz %0d/%0d: got %b, want %b", a, b, res[0], b == 0);
        end else if (b != 0 && (a !== qv * b + rv || rv >= b)) begin
          errors++;
          $display("FAIL sweep_invariant %0d/%0d: got q=%0d r=%0d, want a=q*b+r and r<b", a, b, qv, rv);
        end else if (b == 0 && (qv !== 15 || rv !== a)) begin
          errors++;
          $display("FAIL sweep_zero %0d/0: got q=%0d r=%0d, want q=15 r=%0d", a, qv, rv, a);
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule : tb_seq_restoring_divider
